// File: rtl/clock_display_scanner_if.sv
// Display scanner bundle: binary time fields and mode controls in, multiplexed 7-segment drive out.
// master = upstream time handler / test driver, slave = the scanner itself.
// Ports: disp_hour/min/sec (8b), hour12, pm, blink_field (2b) -> ; <- an (6b one-hot), seg (7b), dp.
interface clock_display_scanner_if;
    logic [7:0] disp_hour;
    logic [7:0] disp_min;
    logic [7:0] disp_sec;
    logic       hour12;
    logic       pm;
    logic [1:0] blink_field;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output disp_hour, disp_min, disp_sec, hour12, pm, blink_field,
        input  an, seg, dp
    );

    modport slave (
        input  disp_hour, disp_min, disp_sec, hour12, pm, blink_field,
        output an, seg, dp
    );
endinterface

// File: rtl/clock_display_scanner.sv
// Six-digit HH MM SS 7-segment scanner with per-frame input snapshot, colon/PM dots, blanking and field blink.
// Latency: an/seg/dp registered one cycle after the digit index; inputs reach the display within 6*SCAN_DIV+1 cycles.
// No backpressure: free-running scan; ports clk, reset (async, active-high), dif (slave modport of clock_display_scanner_if).
module clock_display_scanner #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                     clk,
    input  logic                     reset,
    clock_display_scanner_if.slave   dif
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic {PRIME, SCAN} state_t;

    // One field of the snapshot: dash marks an out-of-range (>99) value.
    typedef struct packed {
        logic       dash;
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    function automatic bcd_t to_bcd(input logic [7:0] v);
        bcd_t r;
        r.dash  = (v > 8'd99);
        r.tens  = r.dash ? 4'd0 : 4'(v / 8'd10);
        r.units = r.dash ? 4'd0 : 4'(v % 8'd10);
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] b);
        logic [6:0] s;
        case (b)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    state_t        state;
    logic [2:0]    d;
    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    bcd_t          snap_hour;
    bcd_t          snap_min;
    bcd_t          snap_sec;
    logic          snap_sec_odd;
    logic          snap_pm;

    logic [5:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    // Next-cycle display drive for digit d.
    bcd_t          cur;
    logic [1:0]    field_code;
    logic [3:0]    digit_val;
    logic          blank;
    logic [5:0]    nxt_an;
    logic [6:0]    nxt_seg;
    logic          nxt_dp;

    always_comb begin
        cur        = snap_hour;
        field_code = 2'b11;
        digit_val  = 4'd0;
        blank      = 1'b0;
        nxt_an     = 6'b000001 << d;
        nxt_seg    = 7'h00;
        nxt_dp     = 1'b0;

        case (d)
            3'd0, 3'd1: begin cur = snap_hour; field_code = 2'b11; end
            3'd2, 3'd3: begin cur = snap_min;  field_code = 2'b10; end
            default:    begin cur = snap_sec;  field_code = 2'b01; end
        endcase

        // Odd digit positions are the units of their field.
        digit_val = d[0] ? cur.units : cur.tens;
        nxt_seg   = cur.dash ? 7'h40 : seg_of(digit_val);

        case (d)
            3'd1, 3'd3: nxt_dp = ~snap_sec_odd;      // colon blinks with the seconds
            3'd5:       nxt_dp = dif.hour12 & snap_pm;
            default:    nxt_dp = 1'b0;
        endcase

        blank = (blink_phase && (dif.blink_field != 2'b00) && (dif.blink_field == field_code))
              || ((d == 3'd0) && dif.hour12 && !snap_hour.dash && (snap_hour.tens == 4'd0));

        // Blanked digits keep their anode enabled so the scan duty stays uniform.
        if (blank) begin
            nxt_seg = 7'h00;
            nxt_dp  = 1'b0;
        end
    end

    // Blink timebase runs independently of the scan and of blink_field changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= PRIME;
            d            <= 3'd0;
            scan_cnt     <= '0;
            snap_hour    <= '0;
            snap_min     <= '0;
            snap_sec     <= '0;
            snap_sec_odd <= 1'b0;
            snap_pm      <= 1'b0;
            an_q         <= 6'd0;
            seg_q        <= 7'd0;
            dp_q         <= 1'b0;
        end else begin
            case (state)
                PRIME: begin
                    snap_hour    <= to_bcd(dif.disp_hour);
                    snap_min     <= to_bcd(dif.disp_min);
                    snap_sec     <= to_bcd(dif.disp_sec);
                    snap_sec_odd <= dif.disp_sec[0];
                    snap_pm      <= dif.pm;
                    d            <= 3'd0;
                    scan_cnt     <= '0;
                    an_q         <= 6'd0;
                    seg_q        <= 7'd0;
                    dp_q         <= 1'b0;
                    state        <= SCAN;
                end
                default: begin
                    an_q  <= nxt_an;
                    seg_q <= nxt_seg;
                    dp_q  <= nxt_dp;
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if (d == 3'd5) begin
                            // Frame boundary: the only point where new time values are taken.
                            d            <= 3'd0;
                            snap_hour    <= to_bcd(dif.disp_hour);
                            snap_min     <= to_bcd(dif.disp_min);
                            snap_sec     <= to_bcd(dif.disp_sec);
                            snap_sec_odd <= dif.disp_sec[0];
                            snap_pm      <= dif.pm;
                        end else begin
                            d <= d + 3'd1;
                        end
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign dif.an  = an_q;
    assign dif.seg = seg_q;
    assign dif.dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scanner.sv
module tb_clock_display_scanner;

    localparam int SD = 4;
    localparam int BD = 16;
    localparam int FRAME = 6 * SD;

    logic clk;
    logic reset;
    clock_display_scanner_if dif();

    clock_display_scanner #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk   (clk),
        .reset (reset),
        .dif   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: edges since reset release plus the values sampled at each frame start.
    int n;
    int m_h, m_m, m_s, m_pm;
    logic [5:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [6:0] seg_tab [10];

    initial begin
        seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
        seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
        seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;
    end

    task automatic tick();
        int p, dig, fld, v, phase, digit;
        logic blank;
        @(posedge clk);
        n++;
        exp_an = 6'd0; exp_seg = 7'd0; exp_dp = 1'b0;
        if (n >= 2) begin
            p     = n - 2;
            dig   = (p / SD) % 6;
            fld   = dig / 2;
            phase = ((n - 1) / BD) % 2;
            v     = (fld == 0) ? m_h : (fld == 1) ? m_m : m_s;
            exp_an = 6'(1 << dig);
            if (v > 99) exp_seg = 7'h40;
            else begin
                digit   = (dig % 2 == 0) ? v / 10 : v % 10;
                exp_seg = seg_tab[digit];
            end
            if (dig == 1 || dig == 3) exp_dp = (m_s % 2 == 0);
            else if (dig == 5)        exp_dp = dif.hour12 && (m_pm != 0);
            blank = (phase == 1 && dif.blink_field != 2'b00 && int'(dif.blink_field) == 3 - fld)
                 || (dig == 0 && dif.hour12 && m_h < 10);
            if (blank) begin exp_seg = 7'd0; exp_dp = 1'b0; end
        end
        if (n >= 1 && (n - 1) % FRAME == 0) begin
            m_h = dif.disp_hour; m_m = dif.disp_min; m_s = dif.disp_sec; m_pm = dif.pm;
        end
        #1;
    endtask

    task automatic set_inputs(input int h, input int m, input int s, input logic h12,
                              input logic pmv, input logic [1:0] bf);
        dif.disp_hour = 8'(h); dif.disp_min = 8'(m); dif.disp_sec = 8'(s);
        dif.hour12 = h12; dif.pm = pmv; dif.blink_field = bf;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if (dif.an !== 6'd0 || dif.seg !== 7'd0 || dif.dp !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: an=%b seg=%h dp=%b want all zero", dif.an, dif.seg, dif.dp);
        end
        apply_reset();
        tick();
        checks++;
        if (dif.an !== 6'd0 || dif.seg !== 7'd0) begin
            errors++;
            $display("FAIL prime_edge: an=%b seg=%h want an=0 seg=0", dif.an, dif.seg);
        end
    endtask

    task automatic test_frame();
        set_inputs(12, 34, 56, 1'b0, 1'b0, 2'b00);
        apply_reset();
        for (int i = 0; i < FRAME + 2; i++) begin
            tick();
            checks++;
            if (dif.an !== exp_an || dif.seg !== exp_seg || dif.dp !== exp_dp) begin
                errors++;
                $display("FAIL frame edge %0d: an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         n, dif.an, dif.seg, dif.dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_snapshot_hold();
        // Continue from test_frame; change minutes mid-frame.
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 10) dif.disp_min = 8'd35;
            tick();
            checks++;
            if (dif.an !== exp_an || dif.seg !== exp_seg || dif.dp !== exp_dp) begin
                errors++;
                $display("FAIL snapshot_hold edge %0d: an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         n, dif.an, dif.seg, dif.dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_clamp();
        set_inputs(12, 34, 120, 1'b0, 1'b0, 2'b00);
        apply_reset();
        for (int i = 0; i < FRAME + 2; i++) begin
            tick();
            checks++;
            if (dif.an !== exp_an || dif.seg !== exp_seg || dif.dp !== exp_dp) begin
                errors++;
                $display("FAIL clamp edge %0d: an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         n, dif.an, dif.seg, dif.dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_blink();
        set_inputs(0, 0, 1, 1'b0, 1'b0, 2'b10);
        apply_reset();
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            checks++;
            if (dif.an !== exp_an || dif.seg !== exp_seg || dif.dp !== exp_dp) begin
                errors++;
                $display("FAIL blink edge %0d: an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         n, dif.an, dif.seg, dif.dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_hour12();
        set_inputs(7, 5, 2, 1'b1, 1'b1, 2'b00);
        apply_reset();
        for (int i = 0; i < FRAME + 2; i++) begin
            tick();
            checks++;
            if (dif.an !== exp_an || dif.seg !== exp_seg || dif.dp !== exp_dp) begin
                errors++;
                $display("FAIL hour12 edge %0d: an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         n, dif.an, dif.seg, dif.dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard;
        set_inputs(9, 41, 27, 1'b0, 1'b0, 2'b00);
        apply_reset();
        guard = 0;
        tick();
        while (exp_an !== 6'b000100 && guard < 4 * FRAME) begin
            tick();
            guard++;
        end
        checks++;
        if (dif.an !== 6'b000100) begin
            errors++;
            $display("FAIL reset_mid_reach: an=%b want 000100", dif.an);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dif.an !== 6'd0 || dif.seg !== 7'd0 || dif.dp !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_clear: an=%b seg=%h dp=%b want all zero", dif.an, dif.seg, dif.dp);
        end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            checks++;
            if (dif.an !== exp_an || dif.seg !== exp_seg || dif.dp !== exp_dp) begin
                errors++;
                $display("FAIL reset_mid_restart edge %0d: an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         n, dif.an, dif.seg, dif.dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_random();
        set_inputs(0, 0, 0, 1'b0, 1'b0, 2'b00);
        apply_reset();
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 6) == 0) dif.disp_hour = 8'($urandom_range(0, 110));
            if ($urandom_range(0, 6) == 0) dif.disp_min  = 8'($urandom_range(0, 110));
            if ($urandom_range(0, 3) == 0) dif.disp_sec  = 8'($urandom_range(0, 110));
            if ($urandom_range(0, 9) == 0) dif.pm        = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 40) == 0) dif.hour12   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 40) == 0) dif.blink_field = 2'($urandom_range(0, 3));
            tick();
            checks++;
            if (dif.an !== exp_an || dif.seg !== exp_seg || dif.dp !== exp_dp) begin
                errors++;
                $display("FAIL random edge %0d: an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         n, dif.an, dif.seg, dif.dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    initial begin
        n = 0; m_h = 0; m_m = 0; m_s = 0; m_pm = 0;
        set_inputs(0, 0, 0, 1'b0, 1'b0, 2'b00);
        test_reset();
        test_frame();
        test_snapshot_hold();
        test_clamp();
        test_blink();
        test_hour12();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
